// File: rtl/gb_cpu_fetch_unit.sv
// GameBoy CPU instruction fetch unit.
// Single-byte bus reads feeding an in-order prefetch queue with redirect.
module gb_cpu_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_rd_req,
  output logic [15:0]                mem_addr,
  input  logic                       mem_rd_valid,
  input  logic [7:0]                 mem_rd_data,
  output logic                       byte_valid,
  output logic [7:0]                 byte_data,
  output logic [15:0]                byte_pc,
  input  logic                       byte_ready,
  input  logic                       redirect_valid,
  input  logic [15:0]                redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] fetch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DROP
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [15:0]     drop_addr_q, drop_addr_d;
  logic [7:0]      data_q [DEPTH];
  logic [7:0]      data_d [DEPTH];
  logic [15:0]     pc_q [DEPTH];
  logic [15:0]     pc_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push;
  logic            pop;
  logic            room;

  assign byte_valid  = (count_q != '0);
  assign byte_data   = data_q[rd_ptr_q];
  assign byte_pc     = pc_q[rd_ptr_q];
  assign fetch_count = count_q;

  // Queue bookkeeping: redirect flushes, otherwise push/pop update pointers.
  always_comb begin
    push     = (state_q == S_FETCH) && mem_rd_valid && !redirect_valid;
    pop      = byte_valid && byte_ready && !redirect_valid;
    data_d   = data_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = mem_rd_data;
        pc_d[wr_ptr_q]   = fetch_pc_q;
        wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
    room = (count_d < FULL);
  end

  // Bus FSM: next state, fetch PC and bus outputs.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    mem_rd_req  = 1'b0;
    mem_addr    = fetch_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (room) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd_req = 1'b1;
        if (mem_rd_valid) begin
          fetch_pc_d = fetch_pc_q + 16'd1;
          state_d    = room ? S_FETCH : S_IDLE;
        end else if (redirect_valid) begin
          drop_addr_d = fetch_pc_q;
          state_d     = S_DROP;
        end
      end
      S_DROP: begin
        mem_rd_req = 1'b1;
        mem_addr   = drop_addr_q;
        if (mem_rd_valid) begin
          state_d = room ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  // State and queue registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      data_q      <= '{default: '0};
      pc_q        <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      data_q      <= data_d;
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(push && count_q == FULL)
  );

endmodule

// File: tb/tb_gb_cpu_fetch_unit.sv
// Directed bench for gb_cpu_fetch_unit.
// Memory model answers addr[7:0] after a programmable number of wait cycles.
module tb_gb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [15:0] byte_pc;
  logic        byte_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [2:0]  fetch_count;

  int checks = 0;
  int errors = 0;
  int wait_cycles = 0;
  int wait_cnt = 0;

  gb_cpu_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_rd_req     (mem_rd_req),
    .mem_addr       (mem_addr),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_pc        (byte_pc),
    .byte_ready     (byte_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  assign mem_rd_valid = mem_rd_req && (wait_cnt >= wait_cycles);
  assign mem_rd_data  = mem_addr[7:0];

  always @(posedge clk) begin
    if (!mem_rd_req || mem_rd_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int wc);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    byte_ready     = 1'b0;
    wait_cycles    = wc;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    // Test 1: reset state and fill to full
    reset_dut(0);
    reset = 1'b1;
    tick();
    chk("rst_req", mem_rd_req, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_valid", byte_valid, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_pc", byte_pc, 0);
    chk("rst_cnt", fetch_count, 0);
    reset = 1'b0;
    chk("c0_req", mem_rd_req, 0);
    tick();
    chk("c1_req", mem_rd_req, 1);
    chk("c1_addr", mem_addr, 16'h0000);
    chk("c1_valid", byte_valid, 0);
    tick();
    chk("c2_valid", byte_valid, 1);
    chk("c2_data", byte_data, 8'h00);
    chk("c2_pc", byte_pc, 16'h0000);
    chk("c2_cnt", fetch_count, 1);
    chk("c2_addr", mem_addr, 16'h0001);
    tick();
    chk("c3_cnt", fetch_count, 2);
    tick();
    chk("c4_cnt", fetch_count, 3);
    tick();
    chk("c5_cnt", fetch_count, 4);
    chk("c5_req", mem_rd_req, 0);
    chk("c5_data", byte_data, 8'h00);
    byte_ready = 1'b1;
    tick();
    chk("c6_data", byte_data, 8'h01);
    chk("c6_pc", byte_pc, 16'h0001);
    chk("c6_cnt", fetch_count, 3);
    tick();
    chk("c7_data", byte_data, 8'h02);

    // Test 2: streaming with byte_ready tied high
    reset_dut(0);
    byte_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("str_valid", byte_valid, 1);
      chk("str_pc", byte_pc, 32'(k));
      chk("str_data", byte_data, 32'(k));
      chk("str_cnt", fetch_count, 1);
      tick();
    end

    // Test 4: redirect with response and pop in same cycle
    reset_dut(0);
    tick();
    tick();
    tick();
    tick();
    chk("t4_cnt3", fetch_count, 3);
    chk("t4_vld", mem_rd_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h1234;
    byte_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    byte_ready     = 1'b0;
    chk("t4_valid", byte_valid, 0);
    chk("t4_cnt", fetch_count, 0);
    chk("t4_addr", mem_addr, 16'h1234);
    chk("t4_req", mem_rd_req, 1);
    tick();
    chk("t4_bvalid", byte_valid, 1);
    chk("t4_bpc", byte_pc, 16'h1234);
    chk("t4_bdata", byte_data, 8'h34);

    // Test 5: PC wrap after redirect to FFFE
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    byte_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("t5_gap", byte_valid, 0);
    chk("t5_addr", mem_addr, 16'hFFFE);
    tick();
    chk("t5_pc0", byte_pc, 16'hFFFE);
    chk("t5_d0", byte_data, 8'hFE);
    chk("t5_v0", byte_valid, 1);
    tick();
    chk("t5_pc1", byte_pc, 16'hFFFF);
    chk("t5_d1", byte_data, 8'hFF);
    tick();
    chk("t5_pc2", byte_pc, 16'h0000);
    chk("t5_d2", byte_data, 8'h00);
    chk("t5_v2", byte_valid, 1);

    // Test 3: redirect during a wait-state read
    reset_dut(3);
    tick();
    chk("t3_req", mem_rd_req, 1);
    chk("t3_vld1", mem_rd_valid, 0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0150;
    tick();
    redirect_valid = 1'b0;
    chk("t3_hold_addr", mem_addr, 16'h0000);
    chk("t3_hold_req", mem_rd_req, 1);
    tick();
    chk("t3_drop_vld", mem_rd_valid, 1);
    chk("t3_drop_addr", mem_addr, 16'h0000);
    tick();
    chk("t3_new_addr", mem_addr, 16'h0150);
    chk("t3_new_req", mem_rd_req, 1);
    chk("t3_discard", fetch_count, 0);
    chk("t3_nobyte", byte_valid, 0);
    n = 0;
    while (!byte_valid && n < 12) begin
      tick();
      n++;
    end
    chk("t3_timeout", 32'(n < 12), 1);
    chk("t3_lat", n, 4);
    chk("t3_pc", byte_pc, 16'h0150);
    chk("t3_data", byte_data, 8'h50);

    // Test 6: reset while in DROP
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0400;
    tick();
    redirect_valid = 1'b0;
    chk("t6_drop_addr", mem_addr, 16'h0151);
    chk("t6_drop_req", mem_rd_req, 1);
    chk("t6_drop_cnt", fetch_count, 0);
    reset = 1'b1;
    tick();
    chk("t6_req", mem_rd_req, 0);
    chk("t6_addr", mem_addr, 16'h0000);
    chk("t6_cnt", fetch_count, 0);
    chk("t6_valid", byte_valid, 0);
    chk("t6_data", byte_data, 0);
    chk("t6_pc", byte_pc, 0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
